// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AddrWDefault = 16;
  localparam int unsigned DataWDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusyDm,
    StBusyIf
  } arb_state_e;

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction buffer: last fetched address/word, with store-hit invalidation.
module mem_arb_ibuf
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrW = AddrWDefault,
  parameter int unsigned DataW = DataWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] lookup_addr_i,
  output logic             hit_o,
  output logic [DataW-1:0] data_o,
  input  logic             fill_i,
  input  logic [AddrW-1:0] fill_addr_i,
  input  logic [DataW-1:0] fill_data_i,
  input  logic             inv_i,
  input  logic [AddrW-1:0] inv_addr_i
);

  logic             valid_q, valid_d;
  logic [AddrW-1:0] tag_q, tag_d;
  logic [DataW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end else if (inv_i && (inv_addr_i == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF and MEM-stage ports; DM always wins, stall until served.
// Define MEM_ARB_IBUF_EN to add a one-entry instruction buffer in front of fetches.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);

  arb_state_e        state_q, state_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_served_q, if_served_d;
  logic              dm_served_q, dm_served_d;

  logic              dm_req;
  logic              dm_issue;
  logic              if_served_eff;
  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_data;

  assign dm_req   = dm_re | dm_we;
  assign dm_issue = (state_q == StIdle) && dm_req && !dm_served_q;

`ifdef MEM_ARB_IBUF_EN
  logic ibuf_match;

  mem_arb_ibuf #(
    .AddrW(ADDR_W),
    .DataW(DATA_W)
  ) u_ibuf (
    .clk_i        (clk),
    .rst_ni       (rst),
    .lookup_addr_i(if_addr),
    .hit_o        (ibuf_match),
    .data_o       (ibuf_data),
    .fill_i       ((state_q == StBusyIf) && mem_rdy),
    .fill_addr_i  (mem_addr_q),
    .fill_data_i  (mem_rdata),
    .inv_i        (dm_issue && dm_we),
    .inv_addr_i   (dm_addr)
  );

  // A hit only counts while idle, so it never races an access already in flight.
  assign ibuf_hit = ibuf_match && if_re && (state_q == StIdle);
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  assign if_served_eff = if_served_q | ibuf_hit;
  assign stall         = (if_re & ~if_served_eff) | (dm_req & ~dm_served_q);

  always_comb begin
    state_d     = state_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_served_d = if_served_q;
    dm_served_d = dm_served_q;

    unique case (state_q)
      StIdle: begin
        if (dm_issue) begin
          state_d     = StBusyDm;
          mem_re_d    = dm_re & ~dm_we;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_re && !if_served_eff) begin
          state_d     = StBusyIf;
          mem_re_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      StBusyDm: begin
        if (mem_rdy) begin
          if (mem_re_q) dm_rdata_d = mem_rdata;
          dm_served_d = 1'b1;
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = StIdle;
        end
      end
      StBusyIf: begin
        if (mem_rdy) begin
          if_rdata_d  = mem_rdata;
          if_served_d = 1'b1;
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ibuf_hit) begin
      if_rdata_d  = ibuf_data;
      if_served_d = 1'b1;
    end

    // Pipeline advanced or request withdrawn: forget that this port was served.
    if (!stall || !if_re)  if_served_d = 1'b0;
    if (!stall || !dm_req) dm_served_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_served_q <= 1'b0;
      dm_served_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_served_q <= if_served_d;
      dm_served_q <= dm_served_d;
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_rdata  = ibuf_hit ? ibuf_data : if_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random transactions against a transaction model.
module tb_mem_arbiter;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_re = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        dm_re = 1'b0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic [15:0] dm_rdata;
  logic        stall;
  logic        mem_re;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdy = 1'b0;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          lat = 0;
  bit          stray = 1'b0;
  acc_t        log_q[$];
  logic [15:0] mem_model[logic [15:0]];
  logic [15:0] pool[0:3];

  // Transaction-level expectations.
  logic [15:0] exp_if = '0;
  logic [15:0] exp_dm = '0;
  bit          buf_v = 1'b0;
  logic [15:0] buf_tag = '0;
  logic [15:0] buf_data = '0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_re    (if_re),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .dm_re    (dm_re),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .stall    (stall),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_rdy  (mem_rdy)
  );

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'h5a5a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory macro: answers each access after `lat` extra busy cycles, logs every busy cycle.
  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_rdata = 16'($urandom);
      if (!rst) begin
        mem_rdy = 1'b0;
        cnt = 0;
      end else if (mem_rdy) begin
        mem_rdy = 1'b0;
        cnt = 0;
      end else if (mem_re || mem_we) begin
        log_q.push_back('{re: mem_re, we: mem_we, addr: mem_addr, wdata: mem_wdata});
        if (cnt >= lat) begin
          mem_rdy = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = rd(mem_addr);
        end else begin
          cnt++;
        end
      end else if (stray) begin
        mem_rdy = 1'b1;
      end
    end
  end

  // Present one pipeline step's requests and hold them until stall drops. Call just after negedge.
  task automatic do_txn(input bit ifr, input logic [15:0] ia, input bit dr, input bit dw,
                        input logic [15:0] da, input logic [15:0] dwd, input int l);
    acc_t        exp_q[$];
    acc_t        obs;
    bit          hit;
    int          n_acc;
    int          stall_cnt;
    logic [15:0] ifv;
    lat = l;
    log_q.delete();
    hit = 1'b0;
`ifdef MEM_ARB_IBUF_EN
    hit = ifr && buf_v && (buf_tag == ia);
`endif
    n_acc = 0;
    ifv = (dw && (da == ia)) ? dwd : rd(ia);
    if (dr || dw) begin
      n_acc++;
      if (!dw) exp_dm = rd(da);
      for (int i = 0; i <= l; i++)
        exp_q.push_back('{re: !dw, we: dw, addr: da, wdata: dw ? dwd : 16'h0});
      if (dw && (buf_tag == da)) buf_v = 1'b0;
    end
    if (hit) begin
      exp_if = buf_data;
    end else if (ifr) begin
      n_acc++;
      exp_if = ifv;
      buf_v = 1'b1;
      buf_tag = ia;
      buf_data = ifv;
      for (int i = 0; i <= l; i++) exp_q.push_back('{re: 1'b1, we: 1'b0, addr: ia, wdata: 16'h0});
    end
    if_re = ifr;
    if_addr = ia;
    dm_re = dr;
    dm_we = dw;
    dm_addr = da;
    dm_wdata = dwd;
    stall_cnt = 0;
    #1;
    while (stall === 1'b1 && stall_cnt < 200) begin
      stall_cnt++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", stall_cnt, n_acc * (2 + l));
    check("access_cycles", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      obs = log_q[i];
      if (!exp_q[i].we) obs.wdata = '0;
      check("access", obs, exp_q[i]);
    end
    check("if_rdata", if_rdata, exp_if);
    check("dm_rdata", dm_rdata, exp_dm);
  endtask

  task automatic go_idle();
    if_re = 1'b0;
    dm_re = 1'b0;
    dm_we = 1'b0;
  endtask

  initial begin
    int w;
    pool[0] = 16'h0010;
    pool[1] = 16'h0040;
    pool[2] = 16'h1234;
    pool[3] = 16'h4000;

    #1;
    check("rst_mem_re", mem_re, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_if_rdata", if_rdata, 16'h0);
    check("rst_dm_rdata", dm_rdata, 16'h0);
    check("rst_stall_idle", stall, 1'b0);
    if_re = 1'b1;
    #1;
    check("rst_stall_live_req", stall, 1'b1);
    if_re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Lone fetch, ready one cycle after issue.
    @(negedge clk);
    mem_model[16'h0010] = 16'hA5A5;
    do_txn(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1);
    check("lone_fetch_word", if_rdata, 16'hA5A5);

    // Simultaneous IF and DM read: DM first.
    @(negedge clk);
    mem_model[16'h4000] = 16'h0F0F;
    mem_model[16'h0020] = 16'h1357;
    do_txn(1'b1, 16'h0020, 1'b1, 1'b0, 16'h4000, 16'h0, 0);

    // Store, and re+we together behaving as a store.
    @(negedge clk);
    do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h1234, 16'hBEEF, 2);
    @(negedge clk);
    do_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h1236, 16'h7777, 0);
    @(negedge clk);
    go_idle();

    // Flush: fetch withdrawn while the access is in flight.
    @(negedge clk);
    lat = 2;
    log_q.delete();
    if_re = 1'b1;
    if_addr = 16'h0050;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("flush_in_flight", mem_re, 1'b1);
    if_re = 1'b0;
    #1;
    check("flush_stall_drop", stall, 1'b0);
    w = 0;
    while ((mem_re !== 1'b0 || log_q.size() < 3) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("flush_completes", w < 20, 1'b1);
    exp_if = rd(16'h0050);
    buf_v = 1'b1;
    buf_tag = 16'h0050;
    buf_data = exp_if;
    check("flush_if_rdata", if_rdata, exp_if);
    @(negedge clk);
    do_txn(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 1);
    @(negedge clk);
    go_idle();

    // Stray ready pulses while idle must be ignored.
    @(negedge clk);
    log_q.delete();
    stray = 1'b1;
    repeat (4) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    #1;
    check("stray_no_access", log_q.size(), 0);
    check("stray_mem_re", mem_re, 1'b0);
    check("stray_if_rdata", if_rdata, exp_if);
    check("stray_dm_rdata", dm_rdata, exp_dm);
    check("stray_stall", stall, 1'b0);

    // Reset in the middle of a store.
    @(negedge clk);
    lat = 5;
    log_q.delete();
    dm_we = 1'b1;
    dm_addr = 16'h2000;
    dm_wdata = 16'h1111;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rmid_busy_we", mem_we, 1'b1);
    rst = 1'b0;
    #1;
    check("rmid_mem_we", mem_we, 1'b0);
    check("rmid_mem_addr", mem_addr, 16'h0);
    check("rmid_mem_wdata", mem_wdata, 16'h0);
    check("rmid_stall", stall, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    exp_if = '0;
    exp_dm = '0;
    buf_v = 1'b0;
    check("rmid_no_write", rd(16'h2000), 16'h2000 ^ 16'h5a5a);
    do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h2000, 16'h1111, 1);
    @(negedge clk);
    go_idle();

`ifdef MEM_ARB_IBUF_EN
    // Repeat fetch hits; a store to the tag forces the next fetch back to memory.
    @(negedge clk);
    do_txn(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    @(negedge clk);
    do_txn(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    check("ibuf_hit_no_read", log_q.size(), 0);
    @(negedge clk);
    do_txn(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hC0DE, 0);
    @(negedge clk);
    do_txn(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 0);
    check("ibuf_miss_word", if_rdata, 16'hC0DE);
    @(negedge clk);
    go_idle();
`endif

    // Random pipeline steps.
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        go_idle();
        @(negedge clk);
      end
      do_txn(1'($urandom), pool[$urandom_range(0, 3)], 1'($urandom), 1'($urandom),
             pool[$urandom_range(0, 3)], 16'($urandom), int'($urandom_range(0, 3)));
    end
    @(negedge clk);
    go_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
